perceptron_train_ctrl: RTL

PERCEPTRON_TRAIN_CTRL -- requirements
Module: perceptron_train_ctrl

---
 rtl/perceptron_train_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_train_ctrl.sv
// perceptron_train_ctrl: training controller for a perceptron branch predictor.
// Resolved branches queue in a 2-entry FIFO. Each one is trained by a
// read-modify-write of one table row. The row is updated one weight per cycle
// through a single saturating adder. Fetch reads always win the shared memory
// port, so training stalls in RD/WR whenever pred_req is high.
// Optional feature: define PTRAIN_THETA_FILTER_EN to drop correctly predicted,
// high-confidence entries (|y| > THETA) without touching the table.
module perceptron_train_ctrl #(
    parameter int H       = 12,
    parameter int W_WIDTH = 8,
    parameter int IDX_W   = 8,
    parameter int THETA   = 29
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     train_valid,
    output logic                     train_ready,
    input  logic [11:0]              train_pc,
    input  logic [H-1:0]             train_ghr,
    input  logic                     train_taken,
    input  logic                     train_mispred,
    input  logic [W_WIDTH+3:0]       train_ymag,
    input  logic                     pred_req,
    input  logic [IDX_W-1:0]         pred_idx,
    output logic                     pred_grant,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [IDX_W-1:0]         mem_addr,
    output logic [(H+1)*W_WIDTH-1:0] mem_wdata,
    input  logic [(H+1)*W_WIDTH-1:0] mem_rdata,
    output logic                     busy,
    output logic                     train_done
);

    localparam int YW = W_WIDTH + 4;
    localparam int KW = $clog2(H + 1);
    localparam logic [KW-1:0] K_LAST = KW'(H);
    localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH-1:0] W_ONE = {{(W_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        UPD  = 3'd3,
        WR   = 3'd4
    } state_t;

    // One step of a saturating counter; a weight already at a rail stays put.
    function automatic logic signed [W_WIDTH-1:0] sat_step(
        input logic signed [W_WIDTH-1:0] w,
        input logic                      up
    );
        logic signed [W_WIDTH-1:0] r;
        if (up) r = (w == W_MAX) ? w : w + W_ONE;
        else    r = (w == W_MIN) ? w : w - W_ONE;
        return r;
    endfunction

    state_t state, state_nx;
    logic [KW-1:0] k, k_nx;

    // FIFO control and storage (row index is folded at push time)
    logic [1:0]       fifo_cnt;
    logic             fifo_wp, fifo_rp;
    logic             fifo_push, fifo_pop;
    logic [IDX_W-1:0] fifo_idx   [2];
    logic [H-1:0]     fifo_ghr   [2];
    logic             fifo_taken [2];
    logic             head_filtered;

    // Entry currently being trained and its row buffer
    logic [IDX_W-1:0]          cur_idx;
    logic [H-1:0]              cur_ghr;
    logic                      cur_taken;
    logic signed [W_WIDTH-1:0] wbuf [H+1];
    logic                      x_pos, upd_up;

    logic unused_pc_hi;
    assign unused_pc_hi = ^train_pc[11:IDX_W];

    assign train_ready = (fifo_cnt != 2'd2);
    assign fifo_push   = train_valid && train_ready;
    assign busy        = (state != IDLE);

`ifdef PTRAIN_THETA_FILTER_EN
    localparam logic [YW-1:0] THETA_V = YW'(THETA);
    logic          fifo_mis  [2];
    logic [YW-1:0] fifo_ymag [2];

    // Filter inputs ride along with the entry so the decision uses push-time values
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mis[fifo_wp]  <= train_mispred;
            fifo_ymag[fifo_wp] <= train_ymag;
        end
    end

    assign head_filtered = !fifo_mis[fifo_rp] && (fifo_ymag[fifo_rp] > THETA_V);
`else
    logic unused_filter_in;
    assign unused_filter_in = ^{train_mispred, train_ymag};
    assign head_filtered    = 1'b0;
`endif

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_cnt <= 2'd0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
        end else begin
            if (fifo_push) fifo_wp <= ~fifo_wp;
            if (fifo_pop)  fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // FIFO payload, written only on push
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_idx[fifo_wp]   <= train_pc[IDX_W-1:0] ^ train_ghr[IDX_W-1:0];
            fifo_ghr[fifo_wp]   <= train_ghr;
            fifo_taken[fifo_wp] <= train_taken;
        end
    end

    // State and weight cursor registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    // Direction of the step for weight k: +1 when outcome agrees with input x_k
    always_comb begin
        x_pos  = (k == '0) ? 1'b1 : cur_ghr[k - 1'b1];
        upd_up = (x_pos == cur_taken);
    end

    // Datapath: capture popped entry, load row buffer, step one weight per cycle
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            cur_idx   <= fifo_idx[fifo_rp];
            cur_ghr   <= fifo_ghr[fifo_rp];
            cur_taken <= fifo_taken[fifo_rp];
        end
        if (state == CAP) begin
            for (int i = 0; i <= H; i++) wbuf[i] <= mem_rdata[i*W_WIDTH +: W_WIDTH];
        end else if (state == UPD) begin
            wbuf[k] <= sat_step(wbuf[k], upd_up);
        end
    end

    // Next state, memory port arbitration (fetch first) and strobes
    always_comb begin
        state_nx   = state;
        k_nx       = k;
        fifo_pop   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        pred_grant = 1'b0;
        train_done = 1'b0;
        if (pred_req) begin
            mem_en     = 1'b1;
            mem_addr   = pred_idx;
            pred_grant = 1'b1;
        end
        case (state)
            IDLE: begin
                if (fifo_cnt != 2'd0) begin
                    fifo_pop = 1'b1;
                    if (!head_filtered) state_nx = RD;
                end
            end
            RD: begin
                if (!pred_req) begin
                    mem_en   = 1'b1;
                    mem_addr = cur_idx;
                    state_nx = CAP;
                end
            end
            CAP: begin
                k_nx     = '0;
                state_nx = UPD;
            end
            UPD: begin
                if (k == K_LAST) begin
                    k_nx     = '0;
                    state_nx = WR;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            WR: begin
                if (!pred_req) begin
                    mem_en     = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = cur_idx;
                    train_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Reset silences the port immediately, including fetch pass-through
        if (!rst) begin
            fifo_pop   = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            pred_grant = 1'b0;
            train_done = 1'b0;
        end
    end

    // Write data presents the row buffer only while writing back
    always_comb begin
        mem_wdata = '0;
        if (state == WR) begin
            for (int i = 0; i <= H; i++) mem_wdata[i*W_WIDTH +: W_WIDTH] = wbuf[i];
        end
    end

endmodule
